// File: rtl/cues_token_injector_arb_pkg.sv
// Shared encodings for the CUES clocked-to-self-timed injector arbiter.
// FSM state encoding and the 4-phase return-to-zero handshake levels.
package cues_token_injector_arb_pkg;

  // state      | meaning
  // -----------+-----------------------------------------------------------
  // ST_IDLE    | no grant held; pick next requester when ack_s is low
  // ST_SETUP   | winner's EXB/CPY driven, one cycle of setup before SEND
  // ST_SEND_HI | SENDOUT high, waiting for synchronised ACK rise
  // ST_SEND_LO | SENDOUT low, waiting for synchronised ACK fall
  // ST_FIN     | DONE pulse to owner, pointer advances
  // ST_ABRT    | watchdog expired, SENDOUT low, wait for ACK low then ABORT
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETUP   = 3'd1,
    ST_SEND_HI = 3'd2,
    ST_SEND_LO = 3'd3,
    ST_FIN     = 3'd4,
    ST_ABRT    = 3'd5
  } state_e;

  // 4-phase return-to-zero levels, shared with the other CUES bridges.
  localparam logic HS_SEND_ASSERT  = 1'b1;
  localparam logic HS_SEND_RELEASE = 1'b0;
  localparam logic HS_ACK_HI       = 1'b1;
  localparam logic HS_ACK_LO       = 1'b0;

  // True in the two phases where the stage owes us an ACK edge.
  function automatic logic in_handshake(input state_e st);
    return (st == ST_SEND_HI) || (st == ST_SEND_LO);
  endfunction

endpackage

// File: rtl/cues_token_injector_arb_ack_sync.sv
// Multi-flop synchroniser for the self-timed stage ACK; resets to 0.
module cues_token_injector_arb_ack_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  // Shift the asynchronous input one flop deeper every clock.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // Synchroniser register chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/cues_token_injector_arb.sv
// Round-robin arbiter sharing one self-timed CUES stage input between
// N_REQ clocked requesters. Drives SEND/EXB/CPY, watches the synchronised
// ACK, and reports DONE or ABORT (watchdog timeout) to the owner.
module cues_token_injector_arb
  import cues_token_injector_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int TMO_W       = 12,
  parameter int TMO_CYC     = 4000
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [N_REQ-1:0]         REQ,
  input  logic [N_REQ-1:0]         EXB_REQ,
  input  logic [N_REQ-1:0]         CPY_REQ,
  input  logic                     ERR_CLR,
  input  logic                     ACKIN,
  output logic                     SENDOUT,
  output logic                     EXBOUT,
  output logic                     CPYOUT,
  output logic [$clog2(N_REQ)-1:0] OWNER,
  output logic                     BUSY,
  output logic [N_REQ-1:0]         DONE,
  output logic [N_REQ-1:0]         ABORT,
  output logic                     ERR
);

  localparam int IDX_W  = $clog2(N_REQ);
  localparam int CAND_W = IDX_W + 1;
  localparam int HOLD_W = $clog2(SYNC_STAGES + 1);
  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               exb_q, exb_d;
  logic               cpy_q, cpy_d;
  logic               send_q, send_d;
  logic [N_REQ-1:0]   done_q, done_d;
  logic [N_REQ-1:0]   abort_q, abort_d;
  logic               err_q, err_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;

  logic               ack_s;
  logic               wdog_tc;
  logic               pick_vld;
  logic [IDX_W-1:0]   pick_idx;
  logic [CAND_W-1:0]  cand;

  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] cur);
    return (cur == IDX_W'(N_REQ - 1)) ? '0 : cur + 1'b1;
  endfunction

  cues_token_injector_arb_ack_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (CLK),
    .rst_n (RESETN),
    .d     (ACKIN),
    .q     (ack_s)
  );

  // Reset leaves the synchroniser at 0 even if the stage still holds ACK
  // high; refuse to grant until the chain has been refilled from ACKIN.
  always_comb begin
    hold_d = hold_q;
    if (hold_q != '0) begin
      hold_d = hold_q - HOLD_W'(1);
    end
  end

  // Round-robin pick: first set REQ bit at or after the pointer, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = {1'b0, ptr_q} + CAND_W'(i);
      if (cand >= CAND_W'(N_REQ)) begin
        cand = cand - CAND_W'(N_REQ);
      end
      if (!pick_vld && REQ[cand[IDX_W-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign wdog_tc = (wdog_q == TMO_W'(TMO_CYC - 1));

  // FSM next state and registered-output next values.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    exb_d   = exb_q;
    cpy_d   = cpy_q;
    send_d  = send_q;
    done_d  = '0;
    abort_d = '0;
    case (state_q)
      ST_IDLE: begin
        if ((hold_q == '0) && pick_vld && (ack_s == HS_ACK_LO)) begin
          state_d = ST_SETUP;
          owner_d = pick_idx;
          exb_d   = EXB_REQ[pick_idx];
          cpy_d   = CPY_REQ[pick_idx];
        end
      end
      ST_SETUP: begin
        state_d = ST_SEND_HI;
        send_d  = HS_SEND_ASSERT;
      end
      ST_SEND_HI: begin
        if (ack_s == HS_ACK_HI) begin
          state_d = ST_SEND_LO;
          send_d  = HS_SEND_RELEASE;
        end else if (wdog_tc) begin
          state_d = ST_ABRT;
          send_d  = HS_SEND_RELEASE;
        end
      end
      ST_SEND_LO: begin
        // A completed handshake takes precedence over a same-cycle timeout.
        if (ack_s == HS_ACK_LO) begin
          state_d = ST_FIN;
          done_d  = ONE_HOT0 << owner_q;
        end else if (wdog_tc) begin
          state_d = ST_ABRT;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        ptr_d   = rr_next(owner_q);
        exb_d   = 1'b0;
        cpy_d   = 1'b0;
      end
      ST_ABRT: begin
        send_d = HS_SEND_RELEASE;
        if (ack_s == HS_ACK_LO) begin
          state_d = ST_IDLE;
          abort_d = ONE_HOT0 << owner_q;
          ptr_d   = rr_next(owner_q);
          exb_d   = 1'b0;
          cpy_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        send_d  = HS_SEND_RELEASE;
        exb_d   = 1'b0;
        cpy_d   = 1'b0;
      end
    endcase
  end

  // Watchdog: zeroed on every state change, counts only while waiting on ACK.
  always_comb begin
    wdog_d = wdog_q;
    if (state_d != state_q) begin
      wdog_d = '0;
    end else if (in_handshake(state_q)) begin
      wdog_d = wdog_q + TMO_W'(1);
    end
  end

  // Sticky error: setting in ABRT beats a simultaneous clear.
  always_comb begin
    err_d = err_q;
    if (ERR_CLR) begin
      err_d = 1'b0;
    end
    if (state_d == ST_ABRT) begin
      err_d = 1'b1;
    end
  end

  // State and output registers; reset drops SENDOUT asynchronously.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      exb_q   <= 1'b0;
      cpy_q   <= 1'b0;
      send_q  <= 1'b0;
      done_q  <= '0;
      abort_q <= '0;
      err_q   <= 1'b0;
      wdog_q  <= '0;
      hold_q  <= HOLD_W'(SYNC_STAGES);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      exb_q   <= exb_d;
      cpy_q   <= cpy_d;
      send_q  <= send_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      err_q   <= err_d;
      wdog_q  <= wdog_d;
      hold_q  <= hold_d;
    end
  end

  assign SENDOUT = send_q;
  assign EXBOUT  = exb_q;
  assign CPYOUT  = cpy_q;
  assign OWNER   = owner_q;
  assign BUSY    = (state_q != ST_IDLE);
  assign DONE    = done_q;
  assign ABORT   = abort_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_cues_token_injector_arb.sv
// Directed bench for cues_token_injector_arb with a simple stage model.
module tb_cues_token_injector_arb;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] exb_req;
  logic [3:0] cpy_req;
  logic       err_clr;
  logic       ackin;
  logic       sendout;
  logic       exbout;
  logic       cpyout;
  logic [1:0] owner;
  logic       busy;
  logic [3:0] done;
  logic [3:0] abort;
  logic       err;

  logic       stage_en;
  int         ack_dly;
  logic       force_ack;
  logic       stage_ack = 1'b0;
  int         stage_cnt = 0;

  int checks = 0;
  int errors = 0;

  assign ackin = stage_ack | force_ack;

  cues_token_injector_arb #(
    .N_REQ       (4),
    .SYNC_STAGES (2),
    .TMO_W       (12),
    .TMO_CYC     (16)
  ) dut (
    .CLK     (clk),
    .RESETN  (rst_n),
    .REQ     (req),
    .EXB_REQ (exb_req),
    .CPY_REQ (cpy_req),
    .ERR_CLR (err_clr),
    .ACKIN   (ackin),
    .SENDOUT (sendout),
    .EXBOUT  (exbout),
    .CPYOUT  (cpyout),
    .OWNER   (owner),
    .BUSY    (busy),
    .DONE    (done),
    .ABORT   (abort),
    .ERR     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stage model: ACK follows SEND after ack_dly falling edges.
  always @(negedge clk) begin
    if (!stage_en || (sendout == stage_ack)) begin
      stage_cnt <= 0;
    end else if (stage_cnt + 1 >= ack_dly) begin
      stage_ack <= sendout;
      stage_cnt <= 0;
    end else begin
      stage_cnt <= stage_cnt + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout reached observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_send(input string tag, input int max);
    int n = 0;
    while (sendout !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(sendout), 32'd1);
  endtask

  task automatic wait_busy(input string tag, input int max);
    int n = 0;
    while (busy !== 1'b1 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(busy), 32'd1);
  endtask

  task automatic wait_done(input string tag, input int max);
    int n = 0;
    while (done === 4'b0000 && n < max) begin
      tick();
      n++;
    end
    chk(tag, 32'(done != 4'b0000), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();
  endtask

  initial begin
    int n;
    rst_n     = 1'b1;
    req       = '0;
    exb_req   = '0;
    cpy_req   = '0;
    err_clr   = 1'b0;
    stage_en  = 1'b0;
    ack_dly   = 3;
    force_ack = 1'b0;
    #2;

    // Reset state
    rst_n = 1'b0;
    #1;
    chk("rst_sendout", 32'(sendout), 32'd0);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_owner",   32'(owner),   32'd0);
    chk("rst_exbout",  32'(exbout),  32'd0);
    chk("rst_cpyout",  32'(cpyout),  32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_abort",   32'(abort),   32'd0);
    chk("rst_err",     32'(err),     32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (4) tick();

    // 1: single requester, ack delay 3
    stage_en = 1'b1;
    ack_dly  = 3;
    req      = 4'b0010;
    exb_req  = 4'b0010;
    cpy_req  = 4'b0000;
    tick();
    chk("t1_send_c1",  32'(sendout), 32'd0);
    chk("t1_busy_c1",  32'(busy),    32'd1);
    chk("t1_owner",    32'(owner),   32'd1);
    chk("t1_exbout",   32'(exbout),  32'd1);
    chk("t1_cpyout",   32'(cpyout),  32'd0);
    tick();
    chk("t1_send_c2",  32'(sendout), 32'd1);
    n = 0;
    while (done === 4'b0000 && n < 40) begin
      chk("t1_exb_hold", 32'(exbout), 32'd1);
      tick();
      n++;
    end
    chk("t1_done",      32'(done),  32'b0010);
    chk("t1_done_lat",  32'(n),     32'd10);
    chk("t1_abort",     32'(abort), 32'd0);
    req = 4'b0000;
    tick();
    chk("t1_done_once", 32'(done),   32'd0);
    chk("t1_exb_clr",   32'(exbout), 32'd0);
    chk("t1_idle",      32'(busy),   32'd0);
    tick();
    chk("t1_no_regrant", 32'(busy),  32'd0);

    // 2: all requesting -> 0,1,2,3,0
    do_reset();
    stage_en = 1'b1;
    ack_dly  = 1;
    exb_req  = 4'b1010;
    cpy_req  = 4'b0101;
    req      = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_done("t2_wait_done", 40);
      chk("t2_done_onehot", 32'(done),   32'(4'b0001 << (k % 4)));
      chk("t2_owner",       32'(owner),  32'(k % 4));
      chk("t2_exbout",      32'(exbout), 32'(k % 2));
      chk("t2_cpyout",      32'(cpyout), 32'((k + 1) % 2));
      if (k == 4) req = 4'b0000;
      tick();
      chk("t2_gap_send",    32'(sendout), 32'd0);
      chk("t2_gap_done",    32'(done),    32'd0);
    end

    // 3: stage never ACKs, timeout after 16 cycles (pointer at 1)
    stage_en = 1'b0;
    exb_req  = 4'b0000;
    cpy_req  = 4'b0000;
    req      = 4'b0100;
    wait_send("t3_wait_send", 10);
    chk("t3_owner", 32'(owner), 32'd2);
    n = 0;
    while (sendout === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("t3_send_len",   32'(n),     32'd16);
    chk("t3_err_set",    32'(err),   32'd1);
    chk("t3_abort_pre",  32'(abort), 32'd0);
    tick();
    chk("t3_abort",      32'(abort), 32'b0100);
    chk("t3_done_none",  32'(done),  32'd0);
    req = 4'b0000;
    tick();
    chk("t3_abort_once", 32'(abort), 32'd0);
    chk("t3_err_sticky", 32'(err),   32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("t3_err_clr",    32'(err),   32'd0);

    // 4: ACK held high through reset release
    stage_en  = 1'b1;
    ack_dly   = 2;
    force_ack = 1'b1;
    rst_n     = 1'b0;
    req       = 4'b0001;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("t4_stale_send", 32'(sendout), 32'd0);
      chk("t4_stale_busy", 32'(busy),    32'd0);
    end
    force_ack = 1'b0;
    tick();
    chk("t4_sync1_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_sync2_busy", 32'(busy), 32'd0);
    tick();
    chk("t4_grant_busy", 32'(busy),    32'd1);
    chk("t4_grant_send", 32'(sendout), 32'd0);
    chk("t4_owner",      32'(owner),   32'd0);
    tick();
    chk("t4_send_rise",  32'(sendout), 32'd1);
    wait_done("t4_wait_done", 40);
    chk("t4_done", 32'(done), 32'b0001);
    req = 4'b0000;
    tick();

    // 5: reset pulsed during SEND_HI (pointer at 1)
    ack_dly = 3;
    req     = 4'b0100;
    exb_req = 4'b0100;
    cpy_req = 4'b0100;
    wait_send("t5_wait_send", 10);
    chk("t5_exb_pre", 32'(exbout), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_send",   32'(sendout), 32'd0);
    chk("t5_busy",   32'(busy),    32'd0);
    chk("t5_owner",  32'(owner),   32'd0);
    chk("t5_exbout", 32'(exbout),  32'd0);
    chk("t5_cpyout", 32'(cpyout),  32'd0);
    chk("t5_done",   32'(done),    32'd0);
    chk("t5_abort",  32'(abort),   32'd0);
    repeat (2) tick();
    chk("t5_done_rst", 32'(done | abort), 32'd0);
    rst_n   = 1'b1;
    req     = 4'b1111;
    exb_req = 4'b0000;
    cpy_req = 4'b0000;
    wait_busy("t5_wait_busy", 10);
    chk("t5_ptr_reset", 32'(owner), 32'd0);
    wait_done("t5_wait_done", 40);
    chk("t5_done_after", 32'(done), 32'b0001);
    req = 4'b0000;
    tick();

    // 6: owner drops REQ and toggles attributes mid-transaction (pointer at 1)
    req     = 4'b0010;
    exb_req = 4'b0010;
    cpy_req = 4'b0010;
    wait_send("t6_wait_send", 10);
    req = 4'b0000;
    n = 0;
    while (done === 4'b0000 && n < 40) begin
      exb_req = ~exb_req;
      cpy_req = ~cpy_req;
      chk("t6_exb_stable", 32'(exbout), 32'd1);
      chk("t6_cpy_stable", 32'(cpyout), 32'd1);
      tick();
      n++;
    end
    chk("t6_done",    32'(done),   32'b0010);
    chk("t6_exb_fin", 32'(exbout), 32'd1);
    tick();
    chk("t6_exb_clr", 32'(exbout), 32'd0);
    chk("t6_idle",    32'(busy),   32'd0);

    // 7: owner keeps requesting through FIN, loses to other requester (pointer at 2)
    exb_req = 4'b0000;
    cpy_req = 4'b0000;
    req     = 4'b0101;
    wait_done("t7_wait_done1", 40);
    chk("t7_done1", 32'(done), 32'b0100);
    tick();
    wait_busy("t7_wait_busy", 10);
    chk("t7_owner2", 32'(owner), 32'd0);
    wait_done("t7_wait_done2", 40);
    chk("t7_done2", 32'(done), 32'b0001);
    req = 4'b0000;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
